// File: rtl/ofmi_ctrl.sv
// rtl/ofmi_ctrl.sv - off-chip memory interface controller: weight load, datapath feed, result write-back
// Optional stall-cycle counter output enabled by defining OFMI_CTRL_STALL_CNT_EN.
module ofmi_ctrl #(
   parameter int ADDR_W   = 16,
   parameter int NUM_CH   = 4,
   parameter int CH_W     = 2,
   parameter int WT_WORDS = 9
) (
   input  logic              OFMI_CTRL_Clk,
   input  logic              OFMI_CTRL_Reset,
   input  logic              OFMI_CTRL_Mst_Start,
   input  logic [1:0]        OFMI_CTRL_Mst_Mode,
   input  logic [ADDR_W-1:0] OFMI_CTRL_Mst_Base,
   input  logic [ADDR_W-1:0] OFMI_CTRL_Mst_Len,
   input  logic              OFMI_CTRL_Mst_Stop,
   input  logic              OFMI_CTRL_Mst_Ack,
   input  logic              OFMI_CTRL_Offmem_Ready,
   output logic              OFMI_CTRL_Mst_Busy,
   output logic              OFMI_CTRL_Mst_Done,
   output logic              OFMI_CTRL_Mst_Err,
   output logic [ADDR_W-1:0] OFMI_CTRL_Offmem_Addr,
   output logic              OFMI_CTRL_Offmem_Re,
   output logic              OFMI_CTRL_Offmem_We,
   output logic [CH_W-1:0]   OFMI_CTRL_Wt_Ch_Sel,
   output logic [NUM_CH-1:0] OFMI_CTRL_Wt_Ch_En,
   output logic              OFMI_CTRL_Dp_En
`ifdef OFMI_CTRL_STALL_CNT_EN
   ,
   output logic [15:0]       OFMI_CTRL_Stall_Cnt
`endif
);

   localparam int WC_W = (WT_WORDS > 1) ? $clog2(WT_WORDS) : 1;
   localparam logic [WC_W-1:0]   WT_LAST  = WC_W'(WT_WORDS - 1);
   localparam logic [ADDR_W-1:0] LOAD_LEN = ADDR_W'(NUM_CH * WT_WORDS);

   localparam logic [1:0] MODE_LOAD  = 2'b00;
   localparam logic [1:0] MODE_FEED  = 2'b01;
   localparam logic [1:0] MODE_WRITE = 2'b10;
   localparam logic [1:0] MODE_ILL   = 2'b11;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t            state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [WC_W-1:0]   wcnt_q, wcnt_d;
   logic              err_q, err_d;

   logic in_run, is_load, is_feed, req, beat, last;

   assign in_run  = (state_q == RUN);
   assign is_load = (mode_q == MODE_LOAD);
   assign is_feed = (mode_q == MODE_FEED);
   assign req     = in_run;
   assign beat    = req & OFMI_CTRL_Offmem_Ready;
   assign last    = (idx_q == len_q - ADDR_W'(1));

   always_ff @(negedge OFMI_CTRL_Clk or negedge OFMI_CTRL_Reset) begin
      if (!OFMI_CTRL_Reset) begin
         state_q <= IDLE;
         mode_q  <= 2'b00;
         base_q  <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         ch_q    <= '0;
         wcnt_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         base_q  <= base_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         ch_q    <= ch_d;
         wcnt_q  <= wcnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      base_d  = base_q;
      len_d   = len_q;
      idx_d   = idx_q;
      ch_d    = ch_q;
      wcnt_d  = wcnt_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (OFMI_CTRL_Mst_Start) begin
               mode_d = OFMI_CTRL_Mst_Mode;
               base_d = OFMI_CTRL_Mst_Base;
               len_d  = (OFMI_CTRL_Mst_Mode == MODE_LOAD) ? LOAD_LEN : OFMI_CTRL_Mst_Len;
               idx_d  = '0;
               ch_d   = '0;
               wcnt_d = '0;
               err_d  = (OFMI_CTRL_Mst_Mode == MODE_ILL);
               if (OFMI_CTRL_Mst_Mode == MODE_ILL || len_d == '0)
                  state_d = DONE;
               else
                  state_d = RUN;
            end
         end
         RUN: begin
            if (beat) begin
               idx_d = idx_q + ADDR_W'(1);
               if (is_load) begin
                  if (wcnt_q == WT_LAST) begin
                     wcnt_d = '0;
                     ch_d   = ch_q + CH_W'(1);
                  end else begin
                     wcnt_d = wcnt_q + WC_W'(1);
                  end
               end
               if (last)
                  state_d = DONE;
            end
            // A pause wins even over the final beat; PAUSE then resolves to DONE on release.
            if (is_feed && OFMI_CTRL_Mst_Stop)
               state_d = PAUSE;
         end
         PAUSE: begin
            if (!OFMI_CTRL_Mst_Stop)
               state_d = (idx_q == len_q) ? DONE : RUN;
         end
         DONE: begin
            if (OFMI_CTRL_Mst_Ack) begin
               state_d = IDLE;
               err_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      OFMI_CTRL_Mst_Busy    = in_run || (state_q == PAUSE);
      OFMI_CTRL_Mst_Done    = (state_q == DONE);
      OFMI_CTRL_Mst_Err     = (state_q == DONE) && err_q;
      OFMI_CTRL_Offmem_Addr = OFMI_CTRL_Mst_Busy ? (base_q + idx_q) : '0;
      OFMI_CTRL_Offmem_Re   = req && (mode_q != MODE_WRITE);
      OFMI_CTRL_Offmem_We   = req && (mode_q == MODE_WRITE);
      OFMI_CTRL_Wt_Ch_Sel   = (in_run && is_load) ? ch_q : '0;
      OFMI_CTRL_Dp_En       = beat && is_feed;
      OFMI_CTRL_Wt_Ch_En    = '0;
      for (int i = 0; i < NUM_CH; i++)
         OFMI_CTRL_Wt_Ch_En[i] = beat && is_load && (ch_q == CH_W'(i));
   end

`ifdef OFMI_CTRL_STALL_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (state_q == IDLE && OFMI_CTRL_Mst_Start)
         stall_cnt_d = '0;
      else if (req && !OFMI_CTRL_Offmem_Ready && stall_cnt_q != 16'hFFFF)
         stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(negedge OFMI_CTRL_Clk or negedge OFMI_CTRL_Reset) begin
      if (!OFMI_CTRL_Reset)
         stall_cnt_q <= '0;
      else
         stall_cnt_q <= stall_cnt_d;
   end

   assign OFMI_CTRL_Stall_Cnt = stall_cnt_q;
`endif

endmodule
